// File: rtl/cache_pkg.sv
// Shared widths, FSM state encoding and address-field helpers for the
// 4-line direct-mapped cache controller.
package cache_pkg;

    localparam int ADDR_W_DEF  = 5;
    localparam int DATA_W_DEF  = 32;
    localparam int INDEX_W_DEF = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_READ,
        MEM_WRITE,
        RESP
    } state_t;

    // Helpers work on a zero-extended 32-bit address; callers size-cast the result.
    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int index_w);
        return addr >> index_w;
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int index_w);
        return addr & ((32'd1 << index_w) - 32'd1);
    endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Valid/tag/data arrays of the direct-mapped cache with combinational hit
// detection and synchronous fill, write-hit update and invalidate.
module cache_tag_store
    import cache_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int INDEX_W = INDEX_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [INDEX_W-1:0]        index,
    input  logic [ADDR_W-INDEX_W-1:0] tag,
    output logic                      hit,
    output logic [DATA_W-1:0]         rd_data,
    input  logic                      fill_en,
    input  logic [DATA_W-1:0]         fill_data,
    input  logic                      upd_en,
    input  logic [DATA_W-1:0]         upd_data
);

    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int LINES = 2 ** INDEX_W;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_arr  [LINES];
    logic [DATA_W-1:0] data_arr [LINES];

    assign hit     = valid[index] && (tag_arr[index] == tag);
    assign rd_data = data_arr[index];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid <= '0;
        end else if (fill_en) begin
            valid[index] <= 1'b1;
        end
    end

    // Tag and data storage is deliberately left unreset; valid bits guard it.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_arr[index]  <= tag;
            data_arr[index] <= fill_data;
        end else if (upd_en) begin
            data_arr[index] <= upd_data;
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// Sequencing controller: request latch, lookup FSM, write-through RAM
// handshake and saturating hit/miss statistics.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int INDEX_W = INDEX_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_flush,
    output logic              cpu_busy,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);

    localparam int TAG_W = ADDR_W - INDEX_W;

    state_t state, next_state;

    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic [DATA_W-1:0]  rd_data;
    logic               flush_en;
    logic               fill_en;
    logic               upd_en;

    assign index = INDEX_W'(addr_index(32'(addr_q), INDEX_W));
    assign tag   = TAG_W'(addr_tag(32'(addr_q), INDEX_W));

    assign flush_en = (state == IDLE) && cpu_flush;
    assign fill_en  = (state == MEM_READ) && mem_ack && !rst;
    assign upd_en   = (state == LOOKUP) && wr_q && hit && !rst;

    cache_tag_store #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .INDEX_W(INDEX_W)
    ) u_tag_store (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush_en),
        .index    (index),
        .tag      (tag),
        .hit      (hit),
        .rd_data  (rd_data),
        .fill_en  (fill_en),
        .fill_data(mem_rdata),
        .upd_en   (upd_en),
        .upd_data (wdata_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && cpu_req && !cpu_flush) begin
            wr_q    <= cpu_wr;
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (!cpu_flush && cpu_req) begin
                    next_state = LOOKUP;
                end
            end
            LOOKUP: begin
                if (wr_q) begin
                    next_state = MEM_WRITE;
                end else if (hit) begin
                    next_state = RESP;
                end else begin
                    next_state = MEM_READ;
                end
            end
            MEM_READ, MEM_WRITE: begin
                if (mem_ack) begin
                    next_state = RESP;
                end
            end
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Every lookup bumps exactly one counter; both stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdata <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            if (state == LOOKUP) begin
                if (hit) begin
                    if (hit_cnt != 16'hFFFF) begin
                        hit_cnt <= hit_cnt + 16'd1;
                    end
                    if (!wr_q) begin
                        cpu_rdata <= rd_data;
                    end
                end else if (miss_cnt != 16'hFFFF) begin
                    miss_cnt <= miss_cnt + 16'd1;
                end
            end
            if (state == MEM_READ && mem_ack) begin
                cpu_rdata <= mem_rdata;
            end
        end
    end

    assign cpu_busy  = (state != IDLE);
    assign cpu_ready = (state == RESP);
    assign mem_en    = (state == MEM_READ) || (state == MEM_WRITE);
    assign mem_wr    = (state == MEM_WRITE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Scoreboard bench for cache_ctrl: directed requests push expected CPU
// responses and RAM accesses; negedge monitors pop and compare them.
module tb_cache_ctrl;

    typedef struct {
        logic [31:0] rdata;
        int          lat;
    } resp_t;

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
    } mem_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_wr;
    logic [4:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_flush;
    logic        cpu_busy;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        mem_en;
    logic        mem_wr;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    resp_t resp_q[$];
    mem_t  mem_q[$];
    resp_t mon_r;
    mem_t  mon_m;

    int n_cmp        = 0;
    int n_fail       = 0;
    int cycle        = 0;
    int accept_cycle = 0;
    int ack_delay    = 1;
    bit ack_hold     = 1'b0;
    int wait_cnt     = 0;
    logic [31:0] ram [32];

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_req  (cpu_req),
        .cpu_wr   (cpu_wr),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_flush(cpu_flush),
        .cpu_busy (cpu_busy),
        .cpu_ready(cpu_ready),
        .cpu_rdata(cpu_rdata),
        .mem_en   (mem_en),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    // RAM model: ack arrives ack_delay cycles after mem_en rises unless held off.
    assign mem_ack   = mem_en && !ack_hold && (wait_cnt >= ack_delay);
    assign mem_rdata = ram[mem_addr];

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                ram[i] <= 32'hA5A5_0000 | 32'(i);
            end
        end else if (mem_en && mem_ack && mem_wr) begin
            ram[mem_addr] <= mem_wdata;
        end
        if (!mem_en || mem_ack) begin
            wait_cnt <= 0;
        end else begin
            wait_cnt <= wait_cnt + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && cpu_ready) begin
            if (resp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL unexpected_ready: got cpu_ready=1 expected no response");
            end else begin
                mon_r = resp_q.pop_front();
                checkOutput("rdata", cpu_rdata, mon_r.rdata);
                checkOutput("latency", 32'(cycle - accept_cycle + 1), 32'(mon_r.lat));
            end
        end
        if (!rst && mem_en && mem_ack) begin
            if (mem_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL unexpected_mem: got access addr=%h wr=%b expected none", mem_addr, mem_wr);
            end else begin
                mon_m = mem_q.pop_front();
                checkOutput("mem_wr", 32'(mem_wr), 32'(mon_m.wr));
                checkOutput("mem_addr", 32'(mem_addr), 32'(mon_m.addr));
                if (mon_m.wr) begin
                    checkOutput("mem_wdata", mem_wdata, mon_m.wdata);
                end
            end
        end
    end

    task automatic applyStimulus(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                                 input logic flush, input bit exp_resp, input logic [31:0] exp_rdata,
                                 input int exp_lat, input bit exp_mem);
        resp_t r;
        mem_t  m;
        int    guard;
        guard = 0;
        @(negedge clk);
        while (cpu_busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (cpu_busy) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL busy_timeout: got cpu_busy=1 expected 0");
        end
        if (exp_resp) begin
            r.rdata = exp_rdata;
            r.lat   = exp_lat;
            resp_q.push_back(r);
        end
        if (exp_mem) begin
            m.wr    = wr;
            m.addr  = addr;
            m.wdata = wdata;
            mem_q.push_back(m);
        end
        cpu_req      = 1'b1;
        cpu_wr       = wr;
        cpu_addr     = addr;
        cpu_wdata    = wdata;
        cpu_flush    = flush;
        accept_cycle = cycle + 1;
        @(negedge clk);
        cpu_req   = 1'b0;
        cpu_flush = 1'b0;
    endtask

    task automatic waitIdle();
        int guard;
        guard = 0;
        while (cpu_busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (cpu_busy) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL idle_timeout: got cpu_busy=1 expected 0");
        end
        @(negedge clk);
    endtask

    task automatic checkCounters(input string tag, input int hits, input int misses);
        checkOutput({tag, "_hit_cnt"}, 32'(hit_cnt), 32'(hits));
        checkOutput({tag, "_miss_cnt"}, 32'(miss_cnt), 32'(misses));
    endtask

    initial begin
        int guard;
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_flush = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(cpu_busy), 32'd0);
        checkOutput("reset_ready", 32'(cpu_ready), 32'd0);
        checkOutput("reset_mem_en", 32'(mem_en), 32'd0);
        checkOutput("reset_mem_wr", 32'(mem_wr), 32'd0);
        checkOutput("reset_rdata", cpu_rdata, 32'd0);
        checkCounters("reset", 0, 0);
        rst = 1'b0;

        $display("[TB] cold read / repeat hit / conflict misses");
        ack_delay = 1;
        applyStimulus(1'b0, 5'h09, 32'h0, 1'b0, 1'b1, 32'hA5A5_0009, 4, 1'b1);
        waitIdle();
        checkCounters("cold", 0, 1);
        applyStimulus(1'b0, 5'h09, 32'h0, 1'b0, 1'b1, 32'hA5A5_0009, 2, 1'b0);
        waitIdle();
        checkCounters("rehit", 1, 1);
        applyStimulus(1'b0, 5'h0D, 32'h0, 1'b0, 1'b1, 32'hA5A5_000D, 4, 1'b1);
        waitIdle();
        applyStimulus(1'b0, 5'h09, 32'h0, 1'b0, 1'b1, 32'hA5A5_0009, 4, 1'b1);
        waitIdle();
        checkCounters("conflict", 1, 3);

        $display("[TB] write-through hit, write miss, no allocate");
        applyStimulus(1'b1, 5'h09, 32'h1234_5678, 1'b0, 1'b1, 32'hA5A5_0009, 4, 1'b1);
        waitIdle();
        applyStimulus(1'b0, 5'h09, 32'h0, 1'b0, 1'b1, 32'h1234_5678, 2, 1'b0);
        waitIdle();
        checkCounters("wr_hit", 3, 3);
        applyStimulus(1'b1, 5'h02, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h1234_5678, 4, 1'b1);
        waitIdle();
        applyStimulus(1'b0, 5'h02, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 4, 1'b1);
        waitIdle();
        checkCounters("wr_miss", 3, 5);

        $display("[TB] zero-latency ack and flush");
        ack_delay = 0;
        applyStimulus(1'b0, 5'h05, 32'h0, 1'b0, 1'b1, 32'hA5A5_0005, 3, 1'b1);
        waitIdle();
        applyStimulus(1'b0, 5'h05, 32'h0, 1'b1, 1'b0, 32'h0, 0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("flush_busy", 32'(cpu_busy), 32'd0);
        checkCounters("flush", 3, 6);
        applyStimulus(1'b0, 5'h02, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 3, 1'b1);
        waitIdle();
        checkCounters("post_flush", 3, 7);

        $display("[TB] reset during MEM_READ");
        ack_delay = 1;
        ack_hold  = 1'b1;
        applyStimulus(1'b0, 5'h0E, 32'h0, 1'b0, 1'b0, 32'h0, 0, 1'b0);
        guard = 0;
        while (!mem_en && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("mem_en_raised", 32'(mem_en), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
        checkOutput("rst_busy", 32'(cpu_busy), 32'd0);
        checkOutput("rst_ready", 32'(cpu_ready), 32'd0);
        checkOutput("rst_rdata", cpu_rdata, 32'd0);
        checkCounters("rst", 0, 0);
        rst      = 1'b0;
        ack_hold = 1'b0;
        applyStimulus(1'b0, 5'h0E, 32'h0, 1'b0, 1'b1, 32'hA5A5_000E, 4, 1'b1);
        waitIdle();
        checkCounters("after_rst", 0, 1);

        repeat (3) @(negedge clk);
        checkOutput("resp_q_empty", 32'(resp_q.size()), 32'd0);
        checkOutput("mem_q_empty", 32'(mem_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Sequencing controller for the 4-line direct-mapped cache in front of `simple_ram`.
- Accepts one CPU request at a time and looks up tag and valid state.
- Serves read hits locally. Fetches and fills the line on a read miss. Write-through on every write.
- Owns the `simple_ram` port through an enable/ack handshake and keeps hit and miss statistics.

Parameters:
- `ADDR_W`, 5: byte-less word address width.
- `DATA_W`, 32: data word width.
- `INDEX_W`, 2: line index width; number of lines is 2**INDEX_W.
- `TAG_W`, derived localparam ADDR_W-INDEX_W (default 3): tag width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous active-high reset.
- `cpu_req`  in  1  request valid; accepted only when cpu_busy=0.
- `cpu_wr`  in  1  1=write, 0=read; sampled with cpu_req.
- `cpu_addr`  in  ADDR_W  address; tag=addr[ADDR_W-1:INDEX_W], index=addr[INDEX_W-1:0].
- `cpu_wdata`  in  DATA_W  write data.
- `cpu_flush`  in  1  invalidate all lines; honoured only in IDLE.
- `cpu_busy`  out  1  high in every state except IDLE.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  DATA_W  read result; registered, valid with cpu_ready.
- `mem_en`  out  1  RAM access request; held until mem_ack.
- `mem_wr`  out  1  RAM write strobe (qualified by mem_en).
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_wdata`  out  DATA_W  RAM write data.
- `mem_rdata`  in  DATA_W  RAM read data; valid when mem_ack=1.
- `mem_ack`  in  1  RAM completion; any latency ≥0 cycles after mem_en rises.
- `hit_cnt`  out  16  saturating hit counter.
- `miss_cnt`  out  16  saturating miss counter.

Behaviour:
- Single clock `clk`; reset `rst` is synchronous and active-high.
- Reset state and values:
  - state=IDLE; all valid bits cleared.
  - cpu_rdata, hit_cnt and miss_cnt are 0.
  - cpu_ready, mem_en and mem_wr are 0.
  - Tag and data arrays are not reset.
- Reset mid-transaction: the transaction is abandoned. No line fill, no cpu_ready. mem_en is low from the cycle after the reset edge.
- Request latch: on an edge with state=IDLE and cpu_req=1, latch cpu_wr, cpu_addr and cpu_wdata, then go to LOOKUP.
- Requests while busy are ignored, not queued.
- IDLE with cpu_flush=1 and cpu_req=1 on the same edge: the flush wins; all valid bits are cleared and the request is dropped, so the requester re-issues it. Flush costs one cycle and produces no cpu_ready.
- LOOKUP (1 cycle): hit = valid[index] && tag_array[index]==tag.
  - Read hit: cpu_rdata <= data_array[index]; hit_cnt++; go to RESP.
  - Read miss: miss_cnt++; go to MEM_READ.
  - Write hit: data_array[index] <= wdata; hit_cnt++; go to MEM_WRITE.
  - Write miss: no allocate, line untouched; miss_cnt++; go to MEM_WRITE.
- MEM_READ: mem_en=1, mem_wr=0, mem_addr=latched addr.
  - On mem_ack: fill data_array[index]=mem_rdata, set tag_array[index]=tag and valid[index]=1.
  - Same edge: cpu_rdata <= mem_rdata; go to RESP.
- MEM_WRITE: mem_en=1, mem_wr=1, mem_addr and mem_wdata from the latched values. On mem_ack, go to RESP.
- RESP: cpu_ready=1 for exactly one cycle, then go to IDLE.
  - cpu_busy is already low during RESP? No: busy stays high in RESP and drops in IDLE.
- mem_en and mem_wr are decoded from the state register. mem_addr and mem_wdata are stable for the whole access.
- Latency, counted as edges from the accept edge to the cpu_ready cycle:
  - Read hit: 2.
  - Miss or write: 3 + (cycles mem_ack is delayed).
- Counters saturate at 0xFFFF with no wrap. Every LOOKUP increments exactly one counter.
- cpu_rdata holds its value until the next read completes; writes do not change it.
- A conflict miss (same index, different tag) overwrites the line; no eviction write-back is needed because the cache is write-through.

Decomposition:
- Package `cache_pkg`:
  - Default widths.
  - State encoding: IDLE, LOOKUP, MEM_READ, MEM_WRITE, RESP.
  - Tag and index extraction functions.
- Sub-module `cache_tag_store`:
  - valid, tag and data arrays.
  - Combinational hit and read-data lookup.
  - Synchronous fill, write-hit update, flush-all and reset-clear.
- `cache_ctrl` holds the FSM, the request latch, the RAM handshake and the counters.

Test Plan:
- Cold read: reset, read addr 5'h09 with RAM[9]=32'hA5A5_0009 and mem_ack 1 cycle after mem_en → one mem_en read at 5'h09; cpu_rdata=A5A50009 with cpu_ready; miss_cnt=1.
- Repeat read of 5'h09 → no mem_en; cpu_ready 2 cycles after accept; data A5A50009; hit_cnt=1.
- Conflict: read 5'h0D (same index 1, tag 3) → miss and refill. Then read 5'h09 → miss again; miss_cnt=3.
- Write-through: write 5'h09 with 32'h1234_5678 while the line is resident → mem_en+mem_wr with that addr and data. The following read of 5'h09 hits and returns 12345678. A write miss to 5'h02 leaves valid[2]=0.
- Flush plus request on the same edge → request dropped, no cpu_ready. The next read of a previously resident address misses.
- Reset while in MEM_READ with mem_ack held low → state IDLE; mem_en=0 next cycle; no cpu_ready; counters 0; line not valid.
